// File: rtl/su_axi_pkg.sv
// Shared encodings, FSM state types and beat-address helper for the AXI slave memory.
package su_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_WAIT  = 2'd1,
    R_BURST = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  // Byte step between consecutive beats; FIXED bursts never move.
  function automatic logic [7:0] beat_addr_incr(input logic [2:0] size, input logic [1:0] burst);
    if (burst == BURST_FIXED) return 8'd0;
    return 8'd1 << size;
  endfunction

endpackage

// File: rtl/su_axi_slave_mem_sram.sv
// Single-clock word RAM: one registered read port (latency 1), one byte-enabled write port.
// A same-cycle read and write of one word returns the old contents.
module su_axi_sram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4096,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rd_en_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [DATA_W-1:0]     rd_data_o,
  input  logic                  wr_en_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic [DATA_W/8-1:0]   wr_strb_i
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (rd_en_i) rd_data_q <= mem_q[rd_idx_i];
    if (wr_en_i) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wr_strb_i[b]) mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/su_axi_slave_mem.sv
// AXI4 slave memory: independent read (R_IDLE/R_WAIT/R_BURST) and write (W_IDLE/W_DATA/W_RESP)
// FSMs, one outstanding transaction each, INCR/FIXED bursts, SLVERR on bad size/burst/range.
module su_axi_slave_mem
  import su_axi_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter int                ID_W      = 4,
  parameter int                DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                RD_LAT    = 2
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                saxi_arvalid_i,
  output logic                saxi_arready_o,
  input  logic [ID_W-1:0]     saxi_arid_i,
  input  logic [ADDR_W-1:0]   saxi_araddr_i,
  input  logic [7:0]          saxi_arlen_i,
  input  logic [2:0]          saxi_arsize_i,
  input  logic [1:0]          saxi_arburst_i,
  input  logic                saxi_arlock_i,
  input  logic [3:0]          saxi_arcache_i,
  input  logic [2:0]          saxi_arprot_i,
  input  logic                saxi_awvalid_i,
  output logic                saxi_awready_o,
  input  logic [ID_W-1:0]     saxi_awid_i,
  input  logic [ADDR_W-1:0]   saxi_awaddr_i,
  input  logic [7:0]          saxi_awlen_i,
  input  logic [2:0]          saxi_awsize_i,
  input  logic [1:0]          saxi_awburst_i,
  input  logic                saxi_awlock_i,
  input  logic [3:0]          saxi_awcache_i,
  input  logic [2:0]          saxi_awprot_i,
  input  logic                saxi_wvalid_i,
  output logic                saxi_wready_o,
  input  logic [DATA_W-1:0]   saxi_wdata_i,
  input  logic [DATA_W/8-1:0] saxi_wstrb_i,
  input  logic                saxi_wlast_i,
  output logic                saxi_rvalid_o,
  input  logic                saxi_rready_i,
  output logic [ID_W-1:0]     saxi_rid_o,
  output logic [DATA_W-1:0]   saxi_rdata_o,
  output logic [1:0]          saxi_rresp_o,
  output logic                saxi_rlast_o,
  output logic                saxi_bvalid_o,
  input  logic                saxi_bready_i,
  output logic [ID_W-1:0]     saxi_bid_o,
  output logic [1:0]          saxi_bresp_o
);

  localparam int LG    = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(DEPTH);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> LG) < ADDR_W'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = (a - BASE_ADDR) >> LG;
    return off[IDX_W-1:0];
  endfunction

  function automatic logic req_bad(input logic [2:0] size, input logic [1:0] burst);
    return (size > 3'(LG)) || !((burst == BURST_FIXED) || (burst == BURST_INCR));
  endfunction

  r_state_e          r_state_q, r_state_d;
  logic [7:0]        lat_q, lat_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [7:0]        rlen_q, rlen_d;
  logic [2:0]        rsize_q, rsize_d;
  logic [1:0]        rburst_q, rburst_d;
  logic [7:0]        rbeat_q, rbeat_d;
  logic              rbad_q, rbad_d;

  w_state_e          w_state_q, w_state_d;
  logic [ID_W-1:0]   wid_q, wid_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wlen_q, wlen_d;
  logic [2:0]        wsize_q, wsize_d;
  logic [1:0]        wburst_q, wburst_d;
  logic [7:0]        wbeat_q, wbeat_d;
  logic              wbad_q, wbad_d;
  logic              werr_q, werr_d;

  logic              ram_rd_en, ram_wr_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rdata;

  logic              r_last, r_beat_err;
  logic [ADDR_W-1:0] r_next_addr, w_next_addr;
  logic              w_beat_last, w_beat_err, w_mismatch;

  assign r_last      = (rbeat_q == rlen_q);
  assign r_beat_err  = rbad_q || !in_range(raddr_q);
  assign r_next_addr = raddr_q + ADDR_W'(beat_addr_incr(rsize_q, rburst_q));
  assign w_beat_last = (wbeat_q == wlen_q);
  assign w_beat_err  = wbad_q || !in_range(waddr_q);
  assign w_mismatch  = (w_beat_last != saxi_wlast_i);
  assign w_next_addr = waddr_q + ADDR_W'(beat_addr_incr(wsize_q, wburst_q));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (saxi_arvalid_i) r_state_d = R_WAIT;
      R_WAIT:  if (lat_q == 8'd0) r_state_d = R_BURST;
      R_BURST: if (saxi_rready_i && r_last) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE:  if (saxi_awvalid_i) w_state_d = W_DATA;
      W_DATA:  if (saxi_wvalid_i && (w_beat_last || saxi_wlast_i)) w_state_d = W_RESP;
      W_RESP:  if (saxi_bready_i) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // The RAM read is issued one cycle ahead of each beat so its registered output lines up with rvalid.
  always_comb begin
    lat_d       = lat_q;
    rid_d       = rid_q;
    raddr_d     = raddr_q;
    rlen_d      = rlen_q;
    rsize_d     = rsize_q;
    rburst_d    = rburst_q;
    rbeat_d     = rbeat_q;
    rbad_d      = rbad_q;
    ram_rd_en   = 1'b0;
    ram_rd_addr = raddr_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (saxi_arvalid_i) begin
          rid_d    = saxi_arid_i;
          raddr_d  = saxi_araddr_i;
          rlen_d   = saxi_arlen_i;
          rsize_d  = saxi_arsize_i;
          rburst_d = saxi_arburst_i;
          rbeat_d  = 8'd0;
          rbad_d   = req_bad(saxi_arsize_i, saxi_arburst_i);
          lat_d    = 8'(RD_LAT - 1);
        end
      end
      R_WAIT: begin
        if (lat_q == 8'd0) ram_rd_en = 1'b1;
        else lat_d = lat_q - 8'd1;
      end
      R_BURST: begin
        if (saxi_rready_i && !r_last) begin
          ram_rd_en   = 1'b1;
          ram_rd_addr = r_next_addr;
          raddr_d     = r_next_addr;
          rbeat_d     = rbeat_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    wid_d     = wid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    wbeat_d   = wbeat_q;
    wbad_d    = wbad_q;
    werr_d    = werr_q;
    ram_wr_en = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (saxi_awvalid_i) begin
          wid_d    = saxi_awid_i;
          waddr_d  = saxi_awaddr_i;
          wlen_d   = saxi_awlen_i;
          wsize_d  = saxi_awsize_i;
          wburst_d = saxi_awburst_i;
          wbeat_d  = 8'd0;
          wbad_d   = req_bad(saxi_awsize_i, saxi_awburst_i);
          werr_d   = 1'b0;
        end
      end
      W_DATA: begin
        if (saxi_wvalid_i) begin
          ram_wr_en = !w_beat_err;
          werr_d    = werr_q || w_beat_err || w_mismatch;
          waddr_d   = w_next_addr;
          wbeat_d   = wbeat_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      lat_q    <= '0;
      rid_q    <= '0;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rsize_q  <= '0;
      rburst_q <= '0;
      rbeat_q  <= '0;
      rbad_q   <= 1'b0;
      wid_q    <= '0;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wsize_q  <= '0;
      wburst_q <= '0;
      wbeat_q  <= '0;
      wbad_q   <= 1'b0;
      werr_q   <= 1'b0;
    end else begin
      lat_q    <= lat_d;
      rid_q    <= rid_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rsize_q  <= rsize_d;
      rburst_q <= rburst_d;
      rbeat_q  <= rbeat_d;
      rbad_q   <= rbad_d;
      wid_q    <= wid_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wsize_q  <= wsize_d;
      wburst_q <= wburst_d;
      wbeat_q  <= wbeat_d;
      wbad_q   <= wbad_d;
      werr_q   <= werr_d;
    end
  end

  // Beat outputs derive only from registers, so they stay put while the master stalls.
  always_comb begin
    saxi_arready_o = (r_state_q == R_IDLE);
    saxi_rvalid_o  = (r_state_q == R_BURST);
    saxi_rid_o     = rid_q;
    saxi_rlast_o   = saxi_rvalid_o && r_last;
    saxi_rresp_o   = (saxi_rvalid_o && r_beat_err) ? RESP_SLVERR : RESP_OKAY;
    saxi_rdata_o   = (saxi_rvalid_o && !r_beat_err) ? ram_rdata : '0;
    saxi_awready_o = (w_state_q == W_IDLE);
    saxi_wready_o  = (w_state_q == W_DATA);
    saxi_bvalid_o  = (w_state_q == W_RESP);
    saxi_bid_o     = wid_q;
    saxi_bresp_o   = (saxi_bvalid_o && werr_q) ? RESP_SLVERR : RESP_OKAY;
  end

  su_axi_sram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_sram (
    .clk_i     (clk_i),
    .rd_en_i   (ram_rd_en),
    .rd_idx_i  (word_idx(ram_rd_addr)),
    .rd_data_o (ram_rdata),
    .wr_en_i   (ram_wr_en),
    .wr_idx_i  (word_idx(waddr_q)),
    .wr_data_i (saxi_wdata_i),
    .wr_strb_i (saxi_wstrb_i)
  );

  logic unused_ok;
  assign unused_ok = ^{saxi_arlock_i, saxi_arcache_i, saxi_arprot_i,
                       saxi_awlock_i, saxi_awcache_i, saxi_awprot_i};

endmodule

// File: tb/tb_su_axi_slave_mem.sv
// Directed bench for su_axi_slave_mem: transaction-level memory model plus per-cycle R/B compare.
module tb_su_axi_slave_mem;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int ID_W   = 4;
  localparam int DEPTH  = 4096;
  localparam int RD_LAT = 2;
  localparam logic [31:0] BASE = 32'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        saxi_arvalid = 0, saxi_arready;
  logic [3:0]  saxi_arid = 0;
  logic [31:0] saxi_araddr = 0;
  logic [7:0]  saxi_arlen = 0;
  logic [2:0]  saxi_arsize = 0;
  logic [1:0]  saxi_arburst = 0;
  logic        saxi_awvalid = 0, saxi_awready;
  logic [3:0]  saxi_awid = 0;
  logic [31:0] saxi_awaddr = 0;
  logic [7:0]  saxi_awlen = 0;
  logic [2:0]  saxi_awsize = 0;
  logic [1:0]  saxi_awburst = 0;
  logic        saxi_wvalid = 0, saxi_wready;
  logic [63:0] saxi_wdata = 0;
  logic [7:0]  saxi_wstrb = 0;
  logic        saxi_wlast = 0;
  logic        saxi_rvalid, saxi_rready = 0;
  logic [3:0]  saxi_rid;
  logic [63:0] saxi_rdata;
  logic [1:0]  saxi_rresp;
  logic        saxi_rlast;
  logic        saxi_bvalid, saxi_bready = 0;
  logic [3:0]  saxi_bid;
  logic [1:0]  saxi_bresp;

  su_axi_slave_mem #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH),
    .BASE_ADDR(BASE), .RD_LAT(RD_LAT)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .saxi_arvalid_i(saxi_arvalid), .saxi_arready_o(saxi_arready),
    .saxi_arid_i(saxi_arid), .saxi_araddr_i(saxi_araddr), .saxi_arlen_i(saxi_arlen),
    .saxi_arsize_i(saxi_arsize), .saxi_arburst_i(saxi_arburst),
    .saxi_arlock_i(1'b0), .saxi_arcache_i(4'h0), .saxi_arprot_i(3'h0),
    .saxi_awvalid_i(saxi_awvalid), .saxi_awready_o(saxi_awready),
    .saxi_awid_i(saxi_awid), .saxi_awaddr_i(saxi_awaddr), .saxi_awlen_i(saxi_awlen),
    .saxi_awsize_i(saxi_awsize), .saxi_awburst_i(saxi_awburst),
    .saxi_awlock_i(1'b0), .saxi_awcache_i(4'h0), .saxi_awprot_i(3'h0),
    .saxi_wvalid_i(saxi_wvalid), .saxi_wready_o(saxi_wready),
    .saxi_wdata_i(saxi_wdata), .saxi_wstrb_i(saxi_wstrb), .saxi_wlast_i(saxi_wlast),
    .saxi_rvalid_o(saxi_rvalid), .saxi_rready_i(saxi_rready),
    .saxi_rid_o(saxi_rid), .saxi_rdata_o(saxi_rdata), .saxi_rresp_o(saxi_rresp),
    .saxi_rlast_o(saxi_rlast),
    .saxi_bvalid_o(saxi_bvalid), .saxi_bready_i(saxi_bready),
    .saxi_bid_o(saxi_bid), .saxi_bresp_o(saxi_bresp)
  );

  int checks = 0;
  int failures = 0;

  typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rbeat_t;
  typedef struct { logic [1:0] resp; logic [3:0] id; } bexp_t;

  logic [63:0] mem_m [DEPTH];
  rbeat_t      rq[$];
  bexp_t       bq[$];
  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  logic [63:0] cap_d [16];
  logic [1:0]  cap_r [16];
  logic        cap_l [16];
  int          cap_lat;
  logic [1:0]  cap_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int i,
                                            input logic [2:0] size, input logic [1:0] burst);
    if (burst == 2'b00) return start;
    return start + 32'(i) * (32'd1 << size);
  endfunction

  function automatic logic beat_bad(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst);
    if (size > 3'd3) return 1'b1;
    if (burst != 2'b00 && burst != 2'b01) return 1'b1;
    if (a < BASE) return 1'b1;
    return ((a - BASE) / 8) >= 32'(DEPTH);
  endfunction

  // Per-cycle compare of R and B channels against the expectation queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (saxi_rvalid) begin
        if (rq.size() == 0) begin
          checks++; failures++;
          $display("FAIL r_unexpected: rvalid=1 rdata=%h with no beat expected", saxi_rdata);
        end else begin
          check("r_data", saxi_rdata, rq[0].data);
          check("r_resp", 64'(saxi_rresp), 64'(rq[0].resp));
          check("r_last", 64'(saxi_rlast), 64'(rq[0].last));
          check("r_id", 64'(saxi_rid), 64'(rq[0].id));
          if (saxi_rready) void'(rq.pop_front());
        end
      end
      if (saxi_bvalid) begin
        if (bq.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_unexpected: bvalid=1 bresp=%h with no response expected", saxi_bresp);
        end else begin
          check("b_resp", 64'(saxi_bresp), 64'(bq[0].resp));
          check("b_id", 64'(saxi_bid), 64'(bq[0].id));
          if (saxi_bready) void'(bq.pop_front());
        end
      end
    end
  end

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int nb);
    bexp_t e; logic bad; logic [31:0] a; int n; logic hs;
    bad = (nb != int'(len) + 1);
    for (int i = 0; i < nb; i++) if (beat_bad(beat_addr(addr, i, size, burst), size, burst)) bad = 1'b1;
    e.resp = bad ? 2'b10 : 2'b00;
    e.id = id;
    bq.push_back(e);
    saxi_awid = id; saxi_awaddr = addr; saxi_awlen = len; saxi_awsize = size; saxi_awburst = burst;
    saxi_awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); hs = saxi_awready; @(posedge clk); #1; n++; end while (!hs && n < 200);
    saxi_awvalid = 1'b0;
    check("aw_handshake", 64'(hs), 64'd1);
    for (int i = 0; i < nb; i++) begin
      saxi_wdata = wd[i]; saxi_wstrb = ws[i]; saxi_wlast = (i == nb - 1); saxi_wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); hs = saxi_wready; @(posedge clk); #1; n++; end while (!hs && n < 200);
      check("w_handshake", 64'(hs), 64'd1);
    end
    saxi_wvalid = 1'b0; saxi_wlast = 1'b0;
    saxi_bready = 1'b1;
    n = 0;
    do begin @(negedge clk); hs = saxi_bvalid; cap_b = saxi_bresp; @(posedge clk); #1; n++; end
      while (!hs && n < 200);
    saxi_bready = 1'b0;
    check("b_handshake", 64'(hs), 64'd1);
    for (int i = 0; i < nb; i++) begin
      a = beat_addr(addr, i, size, burst);
      if (!beat_bad(a, size, burst))
        for (int b = 0; b < 8; b++) if (ws[i][b]) mem_m[(a - BASE) / 8][8*b +: 8] = wd[i][8*b +: 8];
    end
  endtask

  task automatic expect_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    rbeat_t e; logic [31:0] a;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, i, size, burst);
      e.resp = beat_bad(a, size, burst) ? 2'b10 : 2'b00;
      e.data = beat_bad(a, size, burst) ? 64'd0 : mem_m[(a - BASE) / 8];
      e.last = (i == int'(len));
      e.id = id;
      rq.push_back(e);
    end
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n; logic hs;
    saxi_arid = id; saxi_araddr = addr; saxi_arlen = len; saxi_arsize = size; saxi_arburst = burst;
    saxi_arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); hs = saxi_arready; @(posedge clk); #1; n++; end while (!hs && n < 200);
    saxi_arvalid = 1'b0;
    check("ar_handshake", 64'(hs), 64'd1);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [3:0] pat);
    int n, nb, cyc;
    nb = int'(len) + 1;
    expect_read(id, addr, len, size, burst);
    send_ar(id, addr, len, size, burst);
    cap_lat = -1; n = 0; cyc = 0;
    while (n < nb && cyc < 400) begin
      saxi_rready = pat[cyc % 4];
      @(negedge clk);
      if (saxi_rvalid && cap_lat < 0) cap_lat = cyc;
      if (saxi_rvalid && saxi_rready) begin
        cap_d[n] = saxi_rdata; cap_r[n] = saxi_rresp; cap_l[n] = saxi_rlast; n++;
      end
      @(posedge clk); #1; cyc++;
    end
    saxi_rready = 1'b0;
    check("r_beats", 64'(n), 64'(nb));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, cyc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_handshakes", 64'({saxi_arready, saxi_awready, saxi_wready, saxi_rvalid, saxi_bvalid}), 64'b11000);
    check("reset_rdata", saxi_rdata, 64'd0);
    check("reset_misc", 64'({saxi_rid, saxi_rresp, saxi_rlast, saxi_bid, saxi_bresp}), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // single beat write and readback
    wd[0] = 64'hDEADBEEF_CAFEF00D; ws[0] = 8'hFF;
    axi_write(4'h3, 32'h10, 8'd0, 3'd3, 2'b01, 1);
    check("t1_bresp", 64'(cap_b), 64'd0);
    axi_read(4'h5, 32'h10, 8'd0, 3'd3, 2'b01, 4'hF);
    check("t1_data", cap_d[0], 64'hDEADBEEF_CAFEF00D);
    check("t1_last", 64'(cap_l[0]), 64'd1);
    check("t1_latency", 64'(cap_lat), 64'(RD_LAT));

    // INCR burst of 4, read back with stalls
    for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
    axi_write(4'h1, 32'h100, 8'd3, 3'd3, 2'b01, 4);
    axi_read(4'h2, 32'h100, 8'd3, 3'd3, 2'b01, 4'b0101);
    for (int i = 0; i < 4; i++) begin
      check("t2_data", cap_d[i], 64'(i + 1));
      check("t2_last", 64'(cap_l[i]), 64'(i == 3));
    end

    // partial strobe
    wd[0] = '1; ws[0] = 8'hFF;
    axi_write(4'h4, 32'h300, 8'd0, 3'd3, 2'b01, 1);
    wd[0] = 64'd0; ws[0] = 8'h0F;
    axi_write(4'h4, 32'h300, 8'd0, 3'd3, 2'b01, 1);
    axi_read(4'h4, 32'h300, 8'd0, 3'd3, 2'b01, 4'hF);
    check("t3_strobe", cap_d[0], 64'hFFFFFFFF_00000000);

    // burst crossing the top of memory
    wd[0] = 64'h12345678_9ABCDEF0; ws[0] = 8'hFF;
    axi_write(4'h7, 32'h7FF8, 8'd0, 3'd3, 2'b01, 1);
    axi_read(4'h7, 32'h7FF8, 8'd1, 3'd3, 2'b01, 4'hF);
    check("t4_b0_resp", 64'(cap_r[0]), 64'd0);
    check("t4_b0_data", cap_d[0], 64'h12345678_9ABCDEF0);
    check("t4_b1_resp", 64'(cap_r[1]), 64'd2);
    check("t4_b1_data", cap_d[1], 64'd0);

    // WRAP write is rejected and memory untouched
    wd[0] = 64'hBAD0BAD0_BAD0BAD0; wd[1] = 64'hBAD1BAD1_BAD1BAD1; ws[0] = 8'hFF; ws[1] = 8'hFF;
    axi_write(4'h8, 32'h100, 8'd1, 3'd3, 2'b10, 2);
    check("t4_wrap_bresp", 64'(cap_b), 64'd2);
    axi_read(4'h8, 32'h100, 8'd0, 3'd3, 2'b01, 4'hF);
    check("t4_wrap_mem", cap_d[0], 64'd1);

    // oversize read and FIXED read
    axi_read(4'h9, 32'h10, 8'd0, 3'd4, 2'b01, 4'hF);
    check("t4_size_resp", 64'(cap_r[0]), 64'd2);
    axi_read(4'hA, 32'h108, 8'd2, 3'd3, 2'b00, 4'hF);
    check("t4_fixed", cap_d[2], 64'd2);

    // early wlast
    wd[0] = 64'hA0; wd[1] = 64'hA1; ws[0] = 8'hFF; ws[1] = 8'hFF;
    axi_write(4'hB, 32'h500, 8'd3, 3'd3, 2'b01, 2);
    check("t5_early_bresp", 64'(cap_b), 64'd2);
    axi_read(4'hB, 32'h500, 8'd1, 3'd3, 2'b01, 4'hF);
    check("t5_early_data", cap_d[1], 64'hA1);

    // concurrent read and write
    wd[0] = 64'h77; wd[1] = 64'h78; ws[0] = 8'hFF; ws[1] = 8'hFF;
    fork
      axi_write(4'hC, 32'h600, 8'd1, 3'd3, 2'b01, 2);
      axi_read(4'hD, 32'h100, 8'd3, 3'd3, 2'b01, 4'hF);
    join
    check("t5_conc_bresp", 64'(cap_b), 64'd0);
    check("t5_conc_rdata", cap_d[3], 64'd4);
    axi_read(4'hD, 32'h600, 8'd1, 3'd3, 2'b01, 4'hF);
    check("t5_conc_wdata", cap_d[1], 64'h78);

    // reset in the middle of a read burst
    expect_read(4'h6, 32'h100, 8'd3, 3'd3, 2'b01);
    send_ar(4'h6, 32'h100, 8'd3, 3'd3, 2'b01);
    n = 0; cyc = 0; saxi_rready = 1'b1;
    while (n < 2 && cyc < 50) begin
      @(negedge clk);
      if (saxi_rvalid && saxi_rready) n++;
      @(posedge clk); #1; cyc++;
    end
    saxi_rready = 1'b0;
    check("t6_pre_beats", 64'(n), 64'd2);
    @(negedge clk);
    check("t6_pre_rvalid", 64'(saxi_rvalid), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    rq.delete();
    @(posedge clk); #1;
    check("t6_rvalid", 64'(saxi_rvalid), 64'd0);
    check("t6_arready", 64'(saxi_arready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(4'h2, 32'h10, 8'd0, 3'd3, 2'b01, 4'hF);
    check("t6_after", cap_d[0], 64'hDEADBEEF_CAFEF00D);

    repeat (4) @(posedge clk);
    check("r_queue_empty", 64'(rq.size()), 64'd0);
    check("b_queue_empty", 64'(bq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
